// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types and sizing helpers
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Step counter only has to reach width-1, so $clog2(width) bits are enough.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-add multiply step: conditional add of mcand, then right shift
module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, prod_i[2*WIDTH-1:WIDTH]};
    if (prod_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
  end

  // Carry lands in the top bit; the consumed multiplier bit drops off the bottom.
  assign prod_o = {sum, prod_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - sequential unsigned shift-add multiplier, one partial product per clock
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Res,
  output logic                 busy
);

  localparam int CW = cnt_width(WIDTH);

  mul_state_t           state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   res_q;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (prod_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= A;
            prod_q  <= {{WIDTH{1'b0}}, B};
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          prod_q <= prod_d;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            res_q   <= prod_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign Res       = res_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] res;
  logic           busy;

  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;
  bit rand_ready_on = 1'b0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Caller is at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) bound_fail("accept_wait");
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
      pushed++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (lat >= 100) bound_fail("out_valid_wait");
  endtask

  // Scoreboard monitor: pops on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got 0x%0h expected none", res);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", res, mon_e);
        popped++;
      end
    end
  end

  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    rst = 1'b0;
    out_ready = 1'b1;

    // 3*5 accepted on the first edge after reset release; operands then scrambled.
    accept(16'd3, 16'd5, 1'b1);
    in_valid = 1'b0;
    a_in = 16'hDEAD;
    b_in = 16'hBEEF;
    check("busy_after_accept", busy, 1);
    check("in_ready_busy", in_ready, 0);
    wait_valid(lat);
    check("lat_3x5", lat, 16);
    check("res_3x5", res, 32'h0000000F);
    @(posedge clk); #1;
    check("in_ready_after_done", in_ready, 1);
    check("res_held_idle", res, 32'h0000000F);

    accept(16'hFFFF, 16'hFFFF, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("res_ffff", res, 32'hFFFE0001);

    accept(16'h0000, 16'h1234, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat_zero", lat, 16);
    check("res_zero", res, 32'h00000000);

    accept(16'h8000, 16'h0002, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("res_8000x2", res, 32'h00010000);

    // Backpressure: hold DONE while offering new operands that must be ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    accept(16'h1234, 16'h0003, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat_bp", lat, 16);
    for (int i = 0; i < 5; i++) begin
      a_in = 16'h00AA;
      b_in = 16'h00BB;
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_res", res, 32'h0000369C);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    accept(16'h00AA, 16'h00BB, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("res_aaxbb", res, 32'h00007C2E);

    // Abort mid-BUSY with an asynchronous reset.
    accept(16'h1111, 16'h2222, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_res", res, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    accept(16'd6, 16'd7, 1'b1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("lat_6x7", lat, 16);
    check("res_6x7", res, 32'd42);

    // Random stream with random backpressure; in_valid stays high between ops.
    rand_ready_on = 1'b1;
    fork
      begin
        while (rand_ready_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) ra = 16'hFFFF;
      if (i % 13 == 0) rb = 16'h0000;
      accept(ra, rb, 1'b1);
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) bound_fail("drain_wait");
    rand_ready_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", popped, pushed);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
